spi_slave: RTL
==============

# spi_slave

Synthesizable SPI slave, the target-side counterpart of the team's behavioral SPI master used in Verisocks examples. It receives a fixed 8-byte frame: 7 payload bytes, MSB first, followed by a CRC-8 byte. It simultaneously returns 7 response bytes plus their CRC-8 on `miso`. All SPI pins are oversampled in the single system clock domain, and the block presents parallel payload, status and CRC error flags to the surrounding design.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `cs_b`, `sclk`, `mosi`; legal range ≥2.
- `clk`  input  1: system clock.
- `rst`  input  1: asynchronous reset, active-high.
- `cs_b`  input  1: SPI chip select, active low.
- `sclk`  input  1: SPI clock, idle low (mode 0).
- `mosi`  input  1: master out / slave in.
- `miso`  output  1: master in / slave out; driven 0 when no frame is active.
- `tx_data`  input  56: response payload; `[55:48]` is sent first.
- `rx_data`  output  56: last valid payload; `[55:48]` = first byte received.
- `rx_crc`  output  8: CRC byte received in the last valid frame.
- `rx_valid`  output  1: one-cycle pulse, frame complete.
- `rx_crc_err`  output  1: CRC mismatch on the last valid frame; updated with `rx_valid`.
- `frame_abort`  output  1: one-cycle pulse when a frame is discarded.
- `busy`  output  1: high while a frame is in progress.

## Operation
- CRC-8:
  - Polynomial 0x2F, seed 0xFF, non-reflected, no final XOR.
  - Updated bit-serially per bit as `c = {c[6:0],1'b0} ^ ((b ^ c[7]) ? 8'h2F : 8'h00)`.
  - Receive check: running CRC over all 64 received bits must equal 0x00.
- Edges are detected on the synchronized `cs_b` and `sclk`.
- States:
  - IDLE:
    - `cs_b` falling → ACTIVE.
    - On that transition: latch `tx_data` into the tx shifter, seed both CRCs with 0xFF, clear the bit counter, drive bit 55 on `miso`.
  - ACTIVE:
    - `sclk` rising: shift synchronized `mosi` into the rx shifter, update the rx CRC, increment the bit counter (0..63).
    - `sclk` falling: advance `miso`.
      - Bits 0–55 come from the tx shifter; the tx CRC is updated with each bit as it is emitted.
      - Bits 56–63 come from the tx CRC, MSB first.
    - 64th rising edge → FULL.
    - `cs_b` rising before the 64th bit → pulse `frame_abort`, IDLE.
  - FULL:
    - `cs_b` rising → load `rx_data`/`rx_crc`, set `rx_crc_err`, pulse `rx_valid`, IDLE.
    - Any further `sclk` rising → OVERRUN.
    - `miso` = 0 after the last CRC bit.
  - OVERRUN:
    - Ignore bits, `miso` = 0.
    - `cs_b` rising → pulse `frame_abort`, IDLE; `rx_*` unchanged.
- `busy` = state ≠ IDLE.
- `rx_data`, `rx_crc`, `rx_crc_err` hold their values until the next valid frame.
- `tx_data` changes during a frame have no effect on that frame.
- Simultaneous `cs_b` rising and `sclk` edge in the same cycle: `cs_b` wins; the `sclk` edge is ignored.
- Out-of-reset with `cs_b` already low: stay IDLE until a `cs_b` rising edge is followed by a falling edge; no partial frame is ever accepted.

## Timing
- Reset values:
  - `miso`, `rx_valid`, `rx_crc_err`, `frame_abort`, `busy` = 0.
  - `rx_data` = 0, `rx_crc` = 0.
  - State IDLE; all shifters, counters, CRCs = 0; synchronizer flops = idle levels (`cs_b` = 1, `sclk` = 0).
- Reset mid-frame: immediate return to IDLE with reset values; no `rx_valid` or `frame_abort` pulse for the interrupted frame.
- Edge-detect latency: SYNC_STAGES+1 `clk` cycles from pin to internal event.
- `miso` timing:
  - First bit valid SYNC_STAGES+2 cycles after `cs_b` falls.
  - Each following bit changes SYNC_STAGES+2 cycles after `sclk` falls.
- `mosi` is sampled through the same synchronizer depth as `sclk`, so the bit is captured in phase with the detected rising edge.
- `rx_valid` / `frame_abort` pulse SYNC_STAGES+2 cycles after `cs_b` rises; width is exactly one cycle.
- Requirements on the master:
  - `sclk` high and low phases ≥ SYNC_STAGES+3 `clk` periods.
  - `cs_b` falling to first `sclk` rising ≥ SYNC_STAGES+3 periods.
  - `cs_b` high time between frames ≥ 2 periods.
  - At 10 Mbps, 50 % duty, SYNC_STAGES = 2: `clk` ≥ 100 MHz.

## Configuration
- `SPI_SLAVE_CRC_EN` defined:
  - Full CRC generation on bits 56–63.
  - Receive check drives `rx_crc_err`.
- Not defined:
  - CRC logic is removed.
  - Bits 56–63 on `miso` are 0x00.
  - `rx_crc_err` is tied 0.
  - `rx_crc` still captures the received 8th byte.

## Test plan
- Nominal frame:
  - Stimulus: master sends 0x01..0x07 plus the correct CRC; `tx_data` = 0xA1A2A3A4A5A6A7.
  - Required: `rx_data` = 0x01020304050607, `rx_crc_err` = 0, one `rx_valid` pulse.
  - Required: master receives 0xA1..0xA7, and its CRC check over all 8 bytes yields 0x00.
- Corrupted CRC: same frame with the CRC byte XOR 0x01 → `rx_valid` = 1 with `rx_crc_err` = 1; `rx_data` still 0x01020304050607.
- Short frame: `cs_b` rises after 20 bits → `frame_abort` pulses once, no `rx_valid`, `rx_data` keeps its previous value, next full frame is received correctly.
- Overrun: 9 bytes clocked → `frame_abort` pulses, no `rx_valid`, `miso` = 0 during byte 9.
- Reset mid-frame: `rst` pulsed after bit 30 → all outputs at reset values, no pulse. Then with `cs_b` still low: further `sclk` edges are ignored until `cs_b` rises and falls again.
- `SPI_SLAVE_CRC_EN` undefined: corrupted CRC byte → `rx_crc_err` = 0, `rx_crc` = sent byte, master sees 0x00 as the 8th byte.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave: receives a fixed 8-byte frame (7 payload bytes + CRC-8) while returning 7 bytes + CRC.
// Define SPI_SLAVE_CRC_EN to build the CRC-8 generator and receive checker; otherwise rx_crc_err is 0.
`timescale 1ns/1ps

module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_b,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic [55:0] tx_data,
  output logic [55:0] rx_data,
  output logic [7:0]  rx_crc,
  output logic        rx_valid,
  output logic        rx_crc_err,
  output logic        frame_abort,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL, OVERRUN} state_e;

`ifdef SPI_SLAVE_CRC_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((b ^ c[7]) ? 8'h2F : 8'h00);
  endfunction
`endif

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q, live_q;
  logic cs_s, sclk_s, mosi_s;
  logic cs_prev_q, sclk_prev_q, armed_q;
  logic cs_fall_q, cs_rise_q, sclk_rise_q, sclk_fall_q, mosi_bit_q;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // A falling cs_b only counts once cs_b has been seen high with real (post-reset) samples,
  // so a frame already in progress when reset lifts is never picked up half-way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      live_q      <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      mosi_bit_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking here would collapse the synchronizer chain.
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_b};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      live_q      <= {live_q[SYNC_STAGES-2:0], 1'b1};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_q | (live_q[SYNC_STAGES-1] & cs_s);
      cs_fall_q   <= armed_q & cs_prev_q & ~cs_s;
      cs_rise_q   <= ~cs_prev_q & cs_s;
      sclk_rise_q <= ~sclk_prev_q & sclk_s;
      sclk_fall_q <= sclk_prev_q & ~sclk_s;
      mosi_bit_q  <= mosi_s;
    end
  end

  state_e      state_q, state_d;
  logic [55:0] tx_sh_q, tx_sh_d;
  logic [63:0] rx_sh_q, rx_sh_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        miso_q, miso_d;
  logic [55:0] rx_data_q, rx_data_d;
  logic [7:0]  rx_crc_q, rx_crc_d;
  logic        rx_valid_q, rx_valid_d;
  logic        abort_q, abort_d;
`ifdef SPI_SLAVE_CRC_EN
  logic [7:0]  crc_tx_q, crc_tx_d;
  logic [7:0]  crc_rx_q, crc_rx_d;
  logic        rx_crc_err_q, rx_crc_err_d;
`endif

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path through the case infers a latch.
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_crc_d   = rx_crc_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
`ifdef SPI_SLAVE_CRC_EN
    crc_tx_d     = crc_tx_q;
    crc_rx_d     = crc_rx_q;
    rx_crc_err_d = rx_crc_err_q;
`endif
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall_q) begin
          state_d = ACTIVE;
          tx_sh_d = {tx_data[54:0], 1'b0};
          miso_d  = tx_data[55];
          cnt_d   = '0;
`ifdef SPI_SLAVE_CRC_EN
          crc_tx_d = crc8_step(8'hFF, tx_data[55]);
          crc_rx_d = 8'hFF;
`endif
        end
      end
      ACTIVE: begin
        if (cs_rise_q) begin
          state_d = IDLE;
          abort_d = 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_rise_q) begin
          rx_sh_d = {rx_sh_q[62:0], mosi_bit_q};
          cnt_d   = cnt_q + 6'd1;
`ifdef SPI_SLAVE_CRC_EN
          crc_rx_d = crc8_step(crc_rx_q, mosi_bit_q);
`endif
          if (cnt_q == 6'd63) state_d = FULL;
        end else if (sclk_fall_q) begin
          // cnt_q rising edges seen so far, so this falling edge presents bit cnt_q.
          if (cnt_q < 6'd56) begin
            miso_d  = tx_sh_q[55];
            tx_sh_d = {tx_sh_q[54:0], 1'b0};
`ifdef SPI_SLAVE_CRC_EN
            crc_tx_d = crc8_step(crc_tx_q, tx_sh_q[55]);
`endif
          end else begin
`ifdef SPI_SLAVE_CRC_EN
            miso_d   = crc_tx_q[7];
            crc_tx_d = {crc_tx_q[6:0], 1'b0};
`else
            miso_d   = 1'b0;
`endif
          end
        end
      end
      FULL: begin
        if (cs_rise_q) begin
          state_d    = IDLE;
          miso_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q[63:8];
          rx_crc_d   = rx_sh_q[7:0];
`ifdef SPI_SLAVE_CRC_EN
          rx_crc_err_d = (crc_rx_q != 8'h00);
`endif
        end else if (sclk_rise_q) begin
          state_d = OVERRUN;
          miso_d  = 1'b0;
        end else if (sclk_fall_q) begin
          miso_d = 1'b0;
        end
      end
      OVERRUN: begin
        miso_d = 1'b0;
        if (cs_rise_q) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_crc_q   <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
`ifdef SPI_SLAVE_CRC_EN
      crc_tx_q     <= '0;
      crc_rx_q     <= '0;
      rx_crc_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_crc_q   <= rx_crc_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
`ifdef SPI_SLAVE_CRC_EN
      crc_tx_q     <= crc_tx_d;
      crc_rx_q     <= crc_rx_d;
      rx_crc_err_q <= rx_crc_err_d;
`endif
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_crc      = rx_crc_q;
  assign rx_valid    = rx_valid_q;
  assign frame_abort = abort_q;
  assign busy        = (state_q != IDLE);
`ifdef SPI_SLAVE_CRC_EN
  assign rx_crc_err  = rx_crc_err_q;
`else
  assign rx_crc_err  = 1'b0;
`endif

endmodule
